// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int CLKDIV_MIN_DIV = 2;

    // Number of clk_out high cycles in a period of n (the odd extra cycle goes high).
    function automatic int hi_cycles(input int n);
        return n - (n >> 1);
    endfunction

    // Divisors below the minimum would collapse clk_out, so they are raised to it.
    function automatic int clamp_div(input int v);
        if (v < CLKDIV_MIN_DIV) begin
            return CLKDIV_MIN_DIV;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/clk_div_load_ctrl.sv
// Divisor load control: shadow register, pending flag and adoption acknowledge.
module clk_div_load_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    input  logic             adopt_win,
    output logic             adopt,
    output logic [WIDTH-1:0] new_div,
    output logic             div_ack
);

    logic [WIDTH-1:0] shadow_r;
    logic             pending_r;
    logic [WIDTH-1:0] src_s;

    // Adoption decision; a load arriving on the adoption edge bypasses the shadow.
    always_comb begin
        src_s   = shadow_r;
        adopt   = 1'b0;
        if (div_load) begin
            src_s = div_val;
        end else begin
            src_s = shadow_r;
        end
        if (en) begin
            adopt = adopt_win & (pending_r | div_load);
        end else begin
            adopt = pending_r;
        end
        new_div = WIDTH'(clamp_div(int'(src_s)));
    end

    // Shadow capture, pending bookkeeping and the one-cycle ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r  <= '0;
            pending_r <= 1'b0;
            div_ack   <= 1'b0;
        end else begin
            div_ack <= adopt;
            if (adopt) begin
                pending_r <= 1'b0;
            end else if (div_load) begin
                pending_r <= 1'b1;
            end
            if (div_load) begin
                shadow_r <= div_val;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with tick strobe.
// Optional external phase sync (sync_in) is built when CLKDIV_SYNC_EN is defined.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             div_ack,
    output logic [WIDTH-1:0] cur_div,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] eff_div_s;
    logic [WIDTH-1:0] new_div_s;
    logic             wrap_s;
    logic             sync_edge_s;
    logic             adopt_win_s;
    logic             adopt_s;

`ifdef CLKDIV_SYNC_EN
    logic [2:0] sync_r;

    // Two-flop synchroniser plus one history stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], sync_in};
        end
    end

    assign sync_edge_s = sync_r[1] & ~sync_r[2];
`else
    assign sync_edge_s = 1'b0;
`endif

    clk_div_load_ctrl #(
        .WIDTH (WIDTH)
    ) u_load_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_val   (div_val),
        .div_load  (div_load),
        .adopt_win (adopt_win_s),
        .adopt     (adopt_s),
        .new_div   (new_div_s),
        .div_ack   (div_ack)
    );

    // Next count: a wrap or a sync edge both restart the period at zero.
    always_comb begin
        wrap_s      = (cnt_r == (cur_div - WIDTH'(1)));
        adopt_win_s = wrap_s | sync_edge_s;
        if (adopt_s) begin
            eff_div_s = new_div_s;
        end else begin
            eff_div_s = cur_div;
        end
        if (adopt_win_s) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + WIDTH'(1);
        end
    end

    // Counter, divisor and output registers; frozen (except adoption) while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= WIDTH'(DEFAULT_DIV - 1);
            cur_div <= WIDTH'(DEFAULT_DIV);
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (en) begin
            cnt_r   <= cnt_nxt_s;
            clk_out <= (int'(cnt_nxt_s) < hi_cycles(int'(eff_div_s)));
            tick    <= (cnt_nxt_s == '0);
            if (adopt_s) begin
                cur_div <= new_div_s;
            end
        end else begin
            tick <= 1'b0;
            // Parked on the last count so the first enabled edge opens a fresh period.
            if (adopt_s) begin
                cur_div <= new_div_s;
                cnt_r   <= new_div_s - WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: period-level model plus directed literal sequences.
module tb_clk_div_prog;

    localparam int W   = 8;
    localparam int DEF = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         div_load;
    logic         sync_in;
    logic [W-1:0] div_val;
    logic         div_ack;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] cur_div;

    int checks   = 0;
    int failures = 0;

    // Model state: position within the current period and the period length.
    int m_n;
    int m_pos;
    int m_shadow;
    bit m_pend;
    bit m_clk;
    bit m_tick;
    bit m_ack;
    bit hist [3];

    always #5 clk = ~clk;

    clk_div_prog #(
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
`ifdef CLKDIV_SYNC_EN
        .sync_in  (sync_in),
`endif
        .div_ack  (div_ack),
        .cur_div  (cur_div),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_reset();
        m_n      = DEF;
        m_pos    = DEF - 1;
        m_shadow = 0;
        m_pend   = 1'b0;
        m_clk    = 1'b0;
        m_tick   = 1'b0;
        m_ack    = 1'b0;
        hist[0]  = 1'b0;
        hist[1]  = 1'b0;
        hist[2]  = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit l, input int v, input bit s);
        bit sync_hit;
        sync_hit = hist[1] && !hist[2];
        hist[2]  = hist[1];
        hist[1]  = hist[0];
        hist[0]  = s;
        m_ack    = 1'b0;
        if (e) begin
            if (sync_hit || (m_pos == m_n - 1)) begin
                if (m_pend || l) begin
                    m_n    = clampv(l ? v : m_shadow);
                    m_ack  = 1'b1;
                    m_pend = 1'b0;
                end
                m_pos = 0;
            end else begin
                m_pos++;
                if (l) begin
                    m_shadow = v;
                    m_pend   = 1'b1;
                end
            end
            m_clk  = (m_pos < (m_n - m_n / 2));
            m_tick = (m_pos == 0);
        end else begin
            m_tick = 1'b0;
            if (m_pend) begin
                m_n    = clampv(l ? v : m_shadow);
                m_pos  = m_n - 1;
                m_ack  = 1'b1;
                m_pend = 1'b0;
            end else if (l) begin
                m_shadow = v;
                m_pend   = 1'b1;
            end
        end
    endtask

    // Per-cycle comparison against the model, just after every rising edge.
    initial begin : cmp_proc
        bit se;
        bit sl;
        bit ss;
        bit sr;
        int sv;
        model_reset();
        forever begin
            @(posedge clk);
            se = en;
            sl = div_load;
            ss = sync_in;
            sr = rst_n;
            sv = int'(div_val);
            #1;
            if (!sr) begin
                model_reset();
                chk("rst_clk_out", clk_out, 0);
                chk("rst_tick", tick, 0);
                chk("rst_div_ack", div_ack, 0);
                chk("rst_cur_div", cur_div, DEF);
            end else begin
                model_step(se, sl, sv, ss);
                chk("model_clk_out", clk_out, m_clk);
                chk("model_tick", tick, m_tick);
                chk("model_div_ack", div_ack, m_ack);
                chk("model_cur_div", cur_div, m_n);
            end
        end
    end

    task automatic step_chk(input string name, input bit ec, input bit et, input bit ea);
        @(negedge clk);
        chk({name, "_clk_out"}, clk_out, ec);
        chk({name, "_tick"}, tick, et);
        chk({name, "_div_ack"}, div_ack, ea);
    endtask

    // Directed stimulus; bit i of each vector is the expectation after the i-th edge.
    initial begin : stim
        logic [15:0] vc;
        logic [15:0] vt;
        logic [15:0] va;
        rst_n    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        sync_in  = 1'b0;
        repeat (3) @(negedge clk);
        chk("lit_rst_cur_div", cur_div, DEF);
        chk("lit_rst_clk_out", clk_out, 0);

        // N=4 free running from reset
        rst_n = 1'b1;
        en    = 1'b1;
        vc = 16'h0033; vt = 16'h0011; va = 16'h0000;
        for (int i = 0; i < 8; i++) step_chk("t1", vc[i], vt[i], va[i]);

        // load 5 mid-period of N=4
        step_chk("t2pre", 1'b1, 1'b1, 1'b0);
        step_chk("t2pre", 1'b1, 1'b0, 1'b0);
        div_val = 8'd5; div_load = 1'b1;
        vc = 16'h009C; vt = 16'h0084; va = 16'h0004;
        for (int i = 0; i < 8; i++) begin
            step_chk("t2", vc[i], vt[i], va[i]);
            if (i == 0) div_load = 1'b0;
        end
        chk("t2_cur_div", cur_div, 5);

        // div_val=0 clamps to 2
        div_val = 8'd0; div_load = 1'b1;
        vc = 16'h0153; vt = 16'h0150; va = 16'h0010;
        for (int i = 0; i < 9; i++) begin
            step_chk("t3", vc[i], vt[i], va[i]);
            if (i == 0) div_load = 1'b0;
        end
        chk("t3_cur_div", cur_div, 2);

        // N=6, freeze at cnt=2 for 5 cycles
        div_val = 8'd6; div_load = 1'b1;
        vc = 16'h11FE; vt = 16'h1002; va = 16'h0002;
        for (int i = 0; i < 13; i++) begin
            step_chk("t4", vc[i], vt[i], va[i]);
            if (i == 0) div_load = 1'b0;
            if (i == 3) en = 1'b0;
            if (i == 8) en = 1'b1;
        end

        // reset with a pending load
        div_val = 8'd3; div_load = 1'b1;
        step_chk("t5pre", 1'b1, 1'b0, 1'b0);
        div_load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_clk_out", clk_out, 0);
        chk("t5_async_tick", tick, 0);
        chk("t5_async_div_ack", div_ack, 0);
        chk("t5_async_cur_div", cur_div, DEF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vc = 16'h0033; vt = 16'h0011; va = 16'h0000;
        for (int i = 0; i < 8; i++) step_chk("t5", vc[i], vt[i], va[i]);
        chk("t5_cur_div", cur_div, DEF);

        // adoption while disabled parks cnt at N-1
        en = 1'b0; div_val = 8'd3; div_load = 1'b1;
        vc = 16'h002C; vt = 16'h0024; va = 16'h0002;
        for (int i = 0; i < 6; i++) begin
            step_chk("t7", vc[i], vt[i], va[i]);
            if (i == 0) div_load = 1'b0;
            if (i == 1) en = 1'b1;
        end
        chk("t7_cur_div", cur_div, 3);

`ifdef CLKDIV_SYNC_EN
        // N=8, sync_in rises at cnt=4
        div_val = 8'd8; div_load = 1'b1;
        vc = 16'h063D; vt = 16'h0204; va = 16'h0004;
        for (int i = 0; i < 11; i++) begin
            step_chk("t6", vc[i], vt[i], va[i]);
            if (i == 0) div_load = 1'b0;
            if (i == 6) sync_in = 1'b1;
        end
        sync_in = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
